// File: rtl/gru_seq_if.sv
// Stream bundle between the GRU sequencer and its X source / y consumer.
// master: controller view (accepts X, produces y). slave: the attached source/sink.
interface gru_seq_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] x_data;
  logic              x_valid;
  logic              x_ready;
  logic [DATA_W-1:0] y_data;
  logic              y_valid;
  logic              y_ready;
  logic              y_last;

  modport master (
    input  x_data, x_valid, y_ready,
    output x_ready, y_data, y_valid, y_last
  );

  modport slave (
    output x_data, x_valid, y_ready,
    input  x_ready, y_data, y_valid, y_last
  );
endinterface

// File: rtl/gru_seq_controller.sv
// Runs an external combinational GRU/LSTM cell over a sequence of X samples,
// feeding each captured h_out back as the next h_in and streaming it out.
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | x_ready high, waiting for the next X sample
// EVAL  | operands held, cell settling for CELL_LAT cycles
// EMIT  | y_valid held until the consumer takes it
// FIN   | sequence complete, done pulses on the following cycle
module gru_seq_controller #(
  parameter int DATA_W   = 8,
  parameter int LEN_W    = 8,
  parameter int CELL_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  seq_len,
  input  logic [DATA_W-1:0] h_init,
  gru_seq_if.master         strm,
  output logic [DATA_W-1:0] cell_x,
  output logic [DATA_W-1:0] cell_h_in,
  input  logic [DATA_W-1:0] cell_h_out,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] h_final
);

  localparam int SET_W = (CELL_LAT > 1) ? $clog2(CELL_LAT) : 1;
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(CELL_LAT - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_EVAL = 3'd2;
  localparam logic [2:0] S_EMIT = 3'd3;
  localparam logic [2:0] S_FIN  = 3'd4;

  logic [2:0]        state;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  step;
  logic [SET_W-1:0]  settle;
  logic [DATA_W-1:0] h_reg;
  logic [DATA_W-1:0] y_data_q;
  logic              y_valid_q;
  logic              y_last_q;

  assign busy         = (state != S_IDLE);
  assign strm.x_ready = (state == S_LOAD);
  assign strm.y_data  = y_data_q;
  assign strm.y_valid = y_valid_q;
  assign strm.y_last  = y_last_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      len_q     <= '0;
      step      <= '0;
      settle    <= '0;
      h_reg     <= '0;
      cell_x    <= '0;
      cell_h_in <= '0;
      y_data_q  <= '0;
      y_valid_q <= 1'b0;
      y_last_q  <= 1'b0;
      h_final   <= '0;
      done      <= 1'b0;
    end else begin
      done <= (state == S_FIN);
      case (state)
        S_IDLE: begin
          if (start) begin
            if (seq_len != '0) begin
              len_q     <= seq_len;
              h_reg     <= h_init;
              cell_h_in <= h_init;
              step      <= '0;
              state     <= S_LOAD;
            end else begin
              h_final <= h_init;
              state   <= S_FIN;
            end
          end
        end
        S_LOAD: begin
          if (strm.x_valid) begin
            cell_x    <= strm.x_data;
            cell_h_in <= h_reg;
            settle    <= '0;
            state     <= S_EVAL;
          end
        end
        S_EVAL: begin
          settle <= settle + 1'b1;
          if (settle == SETTLE_LAST) begin
            h_reg     <= cell_h_out;
            y_data_q  <= cell_h_out;
            y_valid_q <= 1'b1;
            // len_q is never zero here, so the subtraction cannot wrap
            y_last_q  <= (step == len_q - 1'b1);
            state     <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (strm.y_ready) begin
            y_valid_q <= 1'b0;
            y_last_q  <= 1'b0;
            if (y_last_q) begin
              h_final <= h_reg;
              state   <= S_FIN;
            end else begin
              step  <= step + 1'b1;
              state <= S_LOAD;
            end
          end
        end
        S_FIN:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gru_seq_controller.sv
// Two sequencers (CELL_LAT 1 and 3) driven with the same sequences; a negedge
// monitor checks their streams against queues filled by a plain recurrence model.
module tb_gru_seq_controller;
  localparam int DW   = 8;
  localparam int LW   = 8;
  localparam int LAT0 = 1;
  localparam int LAT1 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, mode;
  logic [LW-1:0] seq_len;
  logic [DW-1:0] h_init;
  logic [DW-1:0] xd [2];
  logic          xv [2];
  logic          yr [2];
  logic          xr [2], yv [2], yl [2], bz [2], dn [2];
  logic [DW-1:0] yd [2], cx [2], ch [2], co [2], hf [2];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  gru_seq_if #(.DATA_W(DW)) bus0 ();
  gru_seq_if #(.DATA_W(DW)) bus1 ();

  assign bus0.x_data = xd[0];  assign bus1.x_data = xd[1];
  assign bus0.x_valid = xv[0]; assign bus1.x_valid = xv[1];
  assign bus0.y_ready = yr[0]; assign bus1.y_ready = yr[1];
  assign xr[0] = bus0.x_ready; assign xr[1] = bus1.x_ready;
  assign yv[0] = bus0.y_valid; assign yv[1] = bus1.y_valid;
  assign yl[0] = bus0.y_last;  assign yl[1] = bus1.y_last;
  assign yd[0] = bus0.y_data;  assign yd[1] = bus1.y_data;

  gru_seq_controller #(.DATA_W(DW), .LEN_W(LW), .CELL_LAT(LAT0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .seq_len(seq_len), .h_init(h_init),
    .strm(bus0), .cell_x(cx[0]), .cell_h_in(ch[0]), .cell_h_out(co[0]),
    .busy(bz[0]), .done(dn[0]), .h_final(hf[0]));

  gru_seq_controller #(.DATA_W(DW), .LEN_W(LW), .CELL_LAT(LAT1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .seq_len(seq_len), .h_init(h_init),
    .strm(bus1), .cell_x(cx[1]), .cell_h_in(ch[1]), .cell_h_out(co[1]),
    .busy(bz[1]), .done(dn[1]), .h_final(hf[1]));

  // Cell stand-in: mode 0 is h+X mod 256, mode 1 a saturating signed h/2+X.
  function automatic logic [DW-1:0] cell_fn(input logic m, input logic [DW-1:0] h, input logic [DW-1:0] x);
    int hs, xs, t;
    if (!m) return h + x;
    hs = int'($signed(h));
    xs = int'($signed(x));
    t  = (hs >>> 1) + xs;
    if (t > 127)  t = 127;
    if (t < -128) t = -128;
    return DW'(t);
  endfunction

  assign co[0] = cell_fn(mode, ch[0], cx[0]);
  assign co[1] = cell_fn(mode, ch[1], cx[1]);

  function automatic int lat_of(input int i);
    return (i == 0) ? LAT0 : LAT1;
  endfunction

  logic [DW-1:0] xq [2][$];
  logic [DW-1:0] hq [2][$];
  logic [DW:0]   yq [2][$];
  logic [DW-1:0] fq [2][$];
  int            dq [2][$];
  logic [DW-1:0] xbuf [256];
  logic          pend [2], in_step [2], pyv [2], pyr [2], pyl [2];
  logic [DW-1:0] last_x [2], last_h [2], pyd [2];
  int            acc_cyc [2], yidx [2], stall_cnt [2], ndone [2], edone [2];
  int            stall_step, yrmode;

  task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d]: got 0x%0h, want 0x%0h (t=%0t)", name, i, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : mon
    logic [DW:0] e;
    int d;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        xq[i].delete(); hq[i].delete(); yq[i].delete(); fq[i].delete(); dq[i].delete();
        pend[i] = 1'b0; xv[i] = 1'b0; in_step[i] = 1'b0; stall_cnt[i] = 0;
        pyv[i] = 1'b0; pyr[i] = 1'b1; yr[i] = 1'b1; ndone[i] = edone[i];
      end else begin
        if (pend[i]) begin pend[i] = 1'b0; xv[i] = 1'b0; end
        if (in_step[i]) begin
          chk("cell_x_hold", i, cx[i], last_x[i]);
          chk("cell_h_in_hold", i, ch[i], last_h[i]);
        end
        if (xq[i].size() == 0) chk("x_ready_idle", i, xr[i], 1'b0);
        if (yv[i]) chk("x_ready_emit", i, xr[i], 1'b0);
        if (!xv[i] && xq[i].size() != 0 && $urandom_range(0, 3) != 0) begin
          xv[i] = 1'b1;
          xd[i] = xq[i][0];
        end
        if (xv[i] && xr[i]) begin
          pend[i]    = 1'b1;
          last_x[i]  = xq[i].pop_front();
          last_h[i]  = hq[i].pop_front();
          acc_cyc[i] = cyc;
          in_step[i] = 1'b1;
        end

        if (yv[i] && !pyv[i]) chk("y_latency", i, cyc - acc_cyc[i], lat_of(i) + 1);
        if (pyv[i] && !pyr[i]) begin
          chk("y_valid_hold", i, yv[i], 1'b1);
          chk("y_data_hold", i, yd[i], pyd[i]);
          chk("y_last_hold", i, yl[i], pyl[i]);
        end
        if (yq[i].size() == 0) chk("y_valid_idle", i, yv[i], 1'b0);
        if (stall_cnt[i] > 0) begin
          yr[i] = 1'b0;
          stall_cnt[i]--;
        end else if (yv[i] && !pyv[i] && yidx[i] == stall_step) begin
          yr[i] = 1'b0;
          stall_cnt[i] = 4;
        end else begin
          yr[i] = (yrmode != 0) ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
        if (yv[i] && yr[i] && yq[i].size() != 0) begin
          e = yq[i].pop_front();
          chk("y_data", i, yd[i], e[DW-1:0]);
          chk("y_last", i, yl[i], e[DW]);
          in_step[i] = 1'b0;
          yidx[i]++;
        end
        pyv[i] = yv[i]; pyr[i] = yr[i]; pyd[i] = yd[i]; pyl[i] = yl[i];

        if (fq[i].size() == 0) chk("done_unexpected", i, dn[i], 1'b0);
        else if (dn[i]) begin
          chk("h_final", i, hf[i], fq[i].pop_front());
          d = dq[i].pop_front();
          if (d >= 0) chk("done_time", i, cyc, d);
          ndone[i]++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    for (int i = 0; i < 2; i++) begin
      chk("rst_x_ready", i, xr[i], 1'b0);
      chk("rst_y_valid", i, yv[i], 1'b0);
      chk("rst_y_last", i, yl[i], 1'b0);
      chk("rst_busy", i, bz[i], 1'b0);
      chk("rst_done", i, dn[i], 1'b0);
      chk("rst_cell_x", i, cx[i], 0);
      chk("rst_cell_h_in", i, ch[i], 0);
      chk("rst_y_data", i, yd[i], 0);
      chk("rst_h_final", i, hf[i], 0);
    end
    tick();
    rst = 1'b0;
  endtask

  // Model: h_k = cell(h_{k-1}, X_k), y_k = h_k, last on k = len-1, h_final = h_len.
  task automatic launch(input logic m, input int len, input logic [DW-1:0] hi,
                        input int stall, input int yrm, input int extra);
    logic [DW-1:0] h;
    mode = m; stall_step = stall; yrmode = yrm;
    for (int i = 0; i < 2; i++) begin
      h = hi;
      yidx[i] = 0;
      for (int k = 0; k < len; k++) begin
        xq[i].push_back(xbuf[k]);
        hq[i].push_back(h);
        h = cell_fn(m, h, xbuf[k]);
        yq[i].push_back({(k == len - 1), h});
      end
      fq[i].push_back(h);
      dq[i].push_back((len == 0) ? cyc + 2 : -1);
      edone[i]++;
    end
    seq_len = LW'(len);
    h_init  = hi;
    start   = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 0; n < extra; n++) begin
      start = 1'b1; seq_len = '0; h_init = ~hi;
      tick();
    end
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((ndone[0] != edone[0] || ndone[1] != edone[1]) && n < 8000) begin
      tick();
      n++;
    end
    chk("seq_complete", 0, (ndone[0] == edone[0] && ndone[1] == edone[1]), 1);
    if (n >= 8000) do_reset();
  endtask

  task automatic rand_x(input int len);
    for (int k = 0; k < len; k++) xbuf[k] = DW'($urandom);
  endtask

  initial begin
    int n, len;
    rst = 1'b1; start = 1'b0; seq_len = '0; h_init = '0; mode = 1'b0;
    stall_step = -1; yrmode = 0;
    for (int i = 0; i < 2; i++) begin
      xv[i] = 1'b0; xd[i] = '0; yr[i] = 1'b1; pend[i] = 1'b0; in_step[i] = 1'b0;
      pyv[i] = 1'b0; pyr[i] = 1'b1; pyl[i] = 1'b0; pyd[i] = '0;
      last_x[i] = '0; last_h[i] = '0; acc_cyc[i] = 0; yidx[i] = 0;
      stall_cnt[i] = 0; ndone[i] = 0; edone[i] = 0;
    end
    do_reset();

    xbuf[0] = 8'h10; xbuf[1] = 8'h20; xbuf[2] = 8'h30;
    launch(1'b0, 3, 8'h00, -1, 0, 0);
    wait_done();

    xbuf[0] = 8'h80; xbuf[1] = 8'h10; xbuf[2] = 8'hF0; xbuf[3] = 8'h01;
    launch(1'b1, 4, 8'h80, -1, 1, 0);
    wait_done();

    rand_x(3);
    launch(1'b0, 3, DW'($urandom), 1, 0, 0);
    wait_done();

    launch(1'b0, 0, 8'h5A, -1, 0, 0);
    wait_done();

    rand_x(3);
    launch(1'b1, 3, DW'($urandom), -1, 0, 3);
    wait_done();

    rand_x(3);
    launch(1'b0, 3, 8'h33, -1, 0, 0);
    n = 0;
    while (!(yv[0] && yidx[0] == 1) && n < 1000) begin tick(); n++; end
    chk("reach_emit_step1", 0, yv[0], 1'b1);
    do_reset();
    rand_x(3);
    launch(1'b0, 3, 8'h33, -1, 0, 0);
    wait_done();

    for (int r = 0; r < 20; r++) begin
      len = $urandom_range(0, 7);
      rand_x(len);
      launch(1'($urandom), len, DW'($urandom), $urandom_range(0, 3), 1,
             (len > 0) ? $urandom_range(0, 3) : 0);
      wait_done();
    end

    rand_x(255);
    launch(1'b0, 255, DW'($urandom), 200, 1, 2);
    wait_done();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/gru_seq_controller.md
Name: gru_seq_controller

Overview:
- Sequencer that runs the combinational gru_lstm_cell (8-bit h_in, X to h_out) over a multi-timestep input sequence.
- Accepts X samples on a valid/ready stream and drives the cell with registered, stable operands.
- After each timestep it captures h_out, feeds it back as the next h_in and emits it on an output stream.
- Sits between the input buffer and downstream consumer; owns the recurrence state and sequence bookkeeping.

Parameters:
- DATA_W, 8: width of X, h and y; signed two's complement, passed through unmodified.
- LEN_W, 8: width of seq_len and step counter.
- CELL_LAT, 1: settle cycles (at least 1) operands are held before cell_h_out is sampled.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin sequence; sampled only in IDLE.
- seq_len  in  LEN_W  number of timesteps; latched on start.
- h_init  in  DATA_W  initial hidden state; latched on start.
- x_data  in  DATA_W  input sample.
- x_valid  in  1  x_data valid.
- x_ready  out  1  controller can accept x_data.
- cell_x  out  DATA_W  registered operand to cell X.
- cell_h_in  out  DATA_W  registered operand to cell h_in.
- cell_h_out  in  DATA_W  cell result.
- y_data  out  DATA_W  hidden state for current step.
- y_valid  out  1  y_data valid.
- y_ready  in  1  consumer accepts y_data.
- y_last  out  1  marks final step; valid with y_valid.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse at sequence end.
- h_final  out  DATA_W  last hidden state; held until next start.

Behaviour:
- Reset (synchronous, active-high, also mid-sequence): state IDLE; x_ready, y_valid, y_last, busy and done are 0; cell_x, cell_h_in, y_data and h_final are 0; step and settle counters are 0. An in-flight sequence is abandoned with no done pulse.
- States: IDLE, LOAD, EVAL, EMIT, FIN.
- IDLE:
  - start=1 with seq_len!=0: latch seq_len; load h_reg<=h_init and cell_h_in<=h_init; step<=0; go to LOAD.
  - start=1 with seq_len==0: go to FIN. No y transfers. h_final<=h_init.
  - start is ignored in every other state.
- LOAD:
  - x_ready=1 only in this state.
  - On x_valid&&x_ready: cell_x<=x_data, cell_h_in<=h_reg, settle<=0; go to EVAL.
  - x_valid low: wait indefinitely.
- EVAL:
  - Operands held constant. settle increments each cycle.
  - In the cycle where settle==CELL_LAT-1: h_reg<=cell_h_out, y_data<=cell_h_out, y_valid<=1, y_last<=(step==seq_len-1); go to EMIT.
- EMIT:
  - y_valid, y_data and y_last are held stable until y_ready (AXI-style; y_valid never drops without a handshake).
  - On handshake with y_last=0: step<=step+1, y_valid<=0; go to LOAD.
  - On handshake with y_last=1: h_final<=h_reg, y_valid<=0; go to FIN.
- FIN: done=1 for exactly one cycle; go to IDLE. busy is 0 again the following cycle.
- Latency:
  - X accepted at edge of cycle t; y_valid rises in cycle t+CELL_LAT+1.
  - Minimum steady-state period is CELL_LAT+2 cycles per step (LOAD, EVAL×CELL_LAT, EMIT) with y_ready tied high.
- Arithmetic: no arithmetic on data. h is passed through bit-exact. The step counter is LEN_W bits wide; seq_len=2^LEN_W-1 must complete without wrap.
- Simultaneous events:
  - start while busy: ignored.
  - x_valid during EVAL or EMIT: not accepted (x_ready=0), so the sample is held by the source.
- cell_x and cell_h_in change only on the LOAD accept edge. They are stable during all EVAL cycles.

Test Plan:
- Basic 3-step run (bench cell stub: h_out=h_in+X mod 256), h_init=0x00, X=0x10,0x20,0x30, y_ready=1: y=0x10,0x30,0x60; y_last only on 0x60; done pulses once; h_final=0x60; y_valid rises 2 cycles after each accept (CELL_LAT=1).
- Signed pass-through with the real gru_lstm_cell, seq_len=4, X=0x80,0x10,0xF0,0x01, h_init=0x80: each y equals the cell output computed combinationally from the previous y and that X; h_final equals the 4th y.
- Backpressure: y_ready low for 5 cycles in step 2: y_valid, y_data and y_last stable for those cycles; x_ready=0 throughout; resumes correctly after release.
- seq_len=0 with start: no x_ready, no y_valid; done pulses 2 cycles after start; h_final=h_init.
- Reset mid-sequence: rst asserted in EMIT of step 1 of 3: next cycle all outputs are 0 and state is IDLE with no done pulse; a new start runs a clean sequence from h_init.
- start re-asserted while busy, plus CELL_LAT=3 build: the sequence is unaffected; y_valid appears 4 cycles after each accept; cell operands are constant across all 3 EVAL cycles.
